ustawianie_unit: RTL and testbench

Bit-set execution block of the execution unit (exe_unit). It takes operand A and a bit index carried in operand B, and returns A with the indexed bit forced to 1. An out-of-range index raises an error flag. The result is registered, giving one-cycle latency, and drives the execution unit's result mux.

---
 rtl/ustawianie_pkg.sv | 14 +
 rtl/ustawianie_dec.sv | 28 ++
 rtl/ustawianie_unit.sv | 55 +++++
 tb/tb_ustawianie_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ustawianie_pkg.sv
// Shared constants for the bit-set operation of the execution unit.
// Holds the default width, index-width helper and the range error code.
package ustawianie_pkg;

    localparam int BITS_DEFAULT = 32;

    // Error code shared with the other exe_unit operations.
    localparam logic ERR_RANGE = 1'b1;

    function automatic int IDX_W(input int bits);
        return $clog2(bits);
    endfunction

endpackage

// File: rtl/ustawianie_dec.sv
// One-hot decoder for the bit index plus the range check on the full index word.
// Only the low IDX_W bits feed the shifter; the full-width compare decides legality.
module ustawianie_dec
    import ustawianie_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic [BITS-1:0] idx,
    output logic [BITS-1:0] mask,
    output logic            in_range
);

    localparam int IW = IDX_W(BITS);

    // BITS always fits in BITS bits when BITS >= 2, so the compare is exact.
    localparam logic [BITS-1:0] LIMIT = BITS[BITS-1:0];
    localparam logic [BITS-1:0] ONE   = {{(BITS-1){1'b0}}, 1'b1};

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        mask     = '0;
        in_range = (idx < LIMIT);
        if (in_range)
            mask = ONE << idx[IW-1:0];
    end

endmodule

// File: rtl/ustawianie_unit.sv
// Bit-set execution block: result = A with bit B set, or 0 with error on a bad index.
// Outputs are registered for one-cycle latency into the exe_unit result mux.
module ustawianie_unit
    import ustawianie_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    output logic [BITS-1:0] o_result,
    output logic            o_error,
    output logic            o_valid
);

    logic [BITS-1:0] mask;
    logic            in_range;
    logic [BITS-1:0] next_result;
    logic            next_error;

    ustawianie_dec #(.BITS(BITS)) u_dec (
        .idx      (i_argB),
        .mask     (mask),
        .in_range (in_range)
    );

    always_comb begin
        next_result = '0;
        next_error  = ERR_RANGE;
        if (in_range) begin
            next_result = i_argA | mask;
            next_error  = ~ERR_RANGE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_result <= '0;
            o_error  <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= i_valid;
            // Result and error hold their last values on idle cycles.
            if (i_valid) begin
                o_result <= next_result;
                o_error  <= next_error;
            end
        end
    end

endmodule

// File: tb/tb_ustawianie_unit.sv
// Self-checking bench for ustawianie_unit: directed scenarios plus a randomized run
// against an arithmetic reference model with one-cycle output latency.
module tb_ustawianie_unit;

    localparam int BITS = 32;

    logic            clk;
    logic            rst;
    logic            valid;
    logic [BITS-1:0] arg_a;
    logic [BITS-1:0] arg_b;
    logic [BITS-1:0] result;
    logic            error;
    logic            out_valid;

    int checks;
    int errors;

    // Reference model state: what the outputs should show after the last edge.
    logic [BITS-1:0] m_res;
    logic            m_err;
    logic            m_valid;

    ustawianie_unit #(.BITS(BITS)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .i_argA   (arg_a),
        .i_argB   (arg_b),
        .o_result (result),
        .o_error  (error),
        .o_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set-bit rule from the operation description, using wide plain arithmetic.
    function automatic logic [BITS:0] model_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        longint unsigned idx;
        longint unsigned val;
        idx = 64'(b);
        if (idx >= 64'(BITS))
            return {1'b1, {BITS{1'b0}}};
        val = 64'(a) | (64'd1 << idx);
        return {1'b0, val[BITS-1:0]};
    endfunction

    // Drive one cycle of inputs away from the edge, then sample 1 time unit after it.
    task automatic cycle(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic v);
        logic [BITS:0] r;
        @(negedge clk);
        arg_a = a;
        arg_b = b;
        valid = v;
        @(posedge clk);
        #1;
        m_valid = v;
        if (v) begin
            r     = model_op(a, b);
            m_err = r[BITS];
            m_res = r[BITS-1:0];
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        arg_a = '0;
        arg_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_res = '0; m_err = 1'b0; m_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, error, result} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_values: got v=%b e=%b r=%h required v=0 e=0 r=00000000", out_valid, error, result);
        end
        cycle(32'h0000_FFFF, 32'd31, 1'b1);
        checks++;
        if ({out_valid, error, result} !== {1'b1, 1'b0, 32'h8000_FFFF}) begin
            errors++;
            $display("FAIL pre_reset_op: got v=%b e=%b r=%h required v=1 e=0 r=8000ffff", out_valid, error, result);
        end
        // Assert reset mid-cycle, away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, error, result} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b e=%b r=%h required all zero", out_valid, error, result);
        end
        valid = 1'b1;
        arg_a = 32'hDEAD_BEEF;
        arg_b = 32'd40;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, error, result} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL valid_in_reset: got v=%b e=%b r=%h required all zero", out_valid, error, result);
        end
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        m_res = '0; m_err = 1'b0; m_valid = 1'b0;
        cycle(32'h0000_0010, 32'd0, 1'b1);
        checks++;
        if ({out_valid, error, result} !== {1'b1, 1'b0, 32'h0000_0011}) begin
            errors++;
            $display("FAIL first_after_reset: got v=%b e=%b r=%h required v=1 e=0 r=00000011", out_valid, error, result);
        end
    endtask

    task automatic test_sweep();
        logic [BITS-1:0] expect_r;
        for (int b = 0; b < BITS; b++) begin
            cycle(32'h0, 32'(b), 1'b1);
            expect_r = 32'h1 << b;
            checks++;
            if ({out_valid, error, result} !== {1'b1, 1'b0, expect_r}) begin
                errors++;
                $display("FAIL sweep_b%0d: got v=%b e=%b r=%h required v=1 e=0 r=%h", b, out_valid, error, result, expect_r);
            end
            for (int k = 0; k < 9; k++)
                cycle($urandom, $urandom, 1'b0);
            checks++;
            if ({out_valid, error, result} !== {1'b0, 1'b0, expect_r}) begin
                errors++;
                $display("FAIL sweep_hold_b%0d: got v=%b e=%b r=%h required v=0 e=0 r=%h", b, out_valid, error, result, expect_r);
            end
        end
    endtask

    task automatic test_already_set();
        cycle(32'h0000_00F0, 32'd4, 1'b1);
        checks++;
        if ({out_valid, error, result} !== {1'b1, 1'b0, 32'h0000_00F0}) begin
            errors++;
            $display("FAIL already_set: got v=%b e=%b r=%h required v=1 e=0 r=000000f0", out_valid, error, result);
        end
        cycle(32'h0000_00F0, 32'd8, 1'b1);
        checks++;
        if ({out_valid, error, result} !== {1'b1, 1'b0, 32'h0000_01F0}) begin
            errors++;
            $display("FAIL set_bit8: got v=%b e=%b r=%h required v=1 e=0 r=000001f0", out_valid, error, result);
        end
    endtask

    task automatic test_out_of_range();
        cycle(32'h1234_5678, 32'd32, 1'b1);
        checks++;
        if ({out_valid, error, result} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL range_b32: got v=%b e=%b r=%h required v=1 e=1 r=00000000", out_valid, error, result);
        end
        cycle(32'h0000_0001, 32'd1, 1'b1);
        cycle(32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        checks++;
        if ({out_valid, error, result} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL range_ones: got v=%b e=%b r=%h required v=1 e=1 r=00000000", out_valid, error, result);
        end
        // Low index field in range but a high bit set must still be illegal.
        cycle(32'h1234_5678, 32'h0001_0003, 1'b1);
        checks++;
        if ({out_valid, error, result} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL range_highbit: got v=%b e=%b r=%h required v=1 e=1 r=00000000", out_valid, error, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] b_list [3];
        logic [BITS-1:0] r_list [3];
        logic            e_list [3];
        b_list = '{32'd3, 32'd5, 32'd40};
        r_list = '{32'h8, 32'h20, 32'h0};
        e_list = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            cycle(32'h0, b_list[i], 1'b1);
            checks++;
            if ({out_valid, error, result} !== {1'b1, e_list[i], r_list[i]}) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b e=%b r=%h required v=1 e=%b r=%h", i, out_valid, error, result, e_list[i], r_list[i]);
            end
        end
        cycle(32'hFFFF_FFFF, 32'd1, 1'b0);
        checks++;
        if ({out_valid, error, result} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL b2b_idle: got v=%b e=%b r=%h required v=0 e=1 r=00000000", out_valid, error, result);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle($urandom, 32'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
            checks++;
            if ({out_valid, error, result} !== {m_valid, m_err, m_res}) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_%0d: got v=%b e=%b r=%h required v=%b e=%b r=%h",
                             i, out_valid, error, result, m_valid, m_err, m_res);
                bad++;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sweep();
        test_already_set();
        test_out_of_range();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
